// File: rtl/store_write_buffer.sv
// Store write buffer: takes committed stores from the store queue, packs them into
// word-granular byte-masked entries (coalescing same-word stores) and drains them in order.
// Packet layout per port: {valid[67], addr[66:35], sign_size[34:32], data[31:0]};
// sign_size[1:0] = 00 byte, 01 half, 1x word, and sign_size[2] (signedness) is ignored.
module store_write_buffer #(
   parameter int NUM_SQ_DCACHE = 2,
   parameter int WB_LEN = 4,
   parameter int WB_IDX_BITS = $clog2(WB_LEN),
   localparam int PKT_W = 68
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic [NUM_SQ_DCACHE-1:0][PKT_W-1:0]   sq_dcache_packet,
   output logic [NUM_SQ_DCACHE-1:0]              dcache_accept,
   output logic                                  mem_req_valid,
   output logic [31:0]                           mem_req_addr,
   output logic [31:0]                           mem_req_data,
   output logic [3:0]                            mem_req_mask,
   input  logic                                  mem_req_ready,
   output logic [WB_IDX_BITS:0]                  wb_count,
   output logic                                  wb_empty
);

   localparam logic [WB_IDX_BITS-1:0] IDX_LAST = WB_IDX_BITS'(WB_LEN - 1);
   localparam logic [WB_IDX_BITS:0]   LEN_C    = (WB_IDX_BITS + 1)'(WB_LEN);

   logic                   e_valid [WB_LEN];
   logic [29:0]            e_waddr [WB_LEN];
   logic [31:0]            e_data  [WB_LEN];
   logic [3:0]             e_mask  [WB_LEN];
   logic [WB_IDX_BITS-1:0] head, tail;
   logic [WB_IDX_BITS:0]   count;

   logic                   n_valid [WB_LEN];
   logic [29:0]            n_waddr [WB_LEN];
   logic [31:0]            n_data  [WB_LEN];
   logic [3:0]             n_mask  [WB_LEN];
   logic [WB_IDX_BITS-1:0] n_head, n_tail, yi;
   logic [WB_IDX_BITS:0]   n_count;
   logic                   blocked, merge, drain, p_valid;
   logic [31:0]            p_addr, p_data, lane_data;
   logic [1:0]             p_size;
   logic [3:0]             lane_mask;
   logic                   unused_sign;

   function automatic logic [WB_IDX_BITS-1:0] next_idx(input logic [WB_IDX_BITS-1:0] i);
      return (i == IDX_LAST) ? '0 : i + 1'b1;
   endfunction

   always_comb begin
      n_valid     = e_valid;
      n_waddr     = e_waddr;
      n_data      = e_data;
      n_mask      = e_mask;
      n_head      = head;
      n_tail      = tail;
      n_count     = count;
      blocked     = reset;
      merge       = 1'b0;
      yi          = '0;
      p_valid     = 1'b0;
      p_addr      = '0;
      p_data      = '0;
      p_size      = '0;
      lane_mask   = '0;
      lane_data   = '0;
      unused_sign = 1'b0;
      dcache_accept = '0;

      // Ports are placed oldest-first; the first refusal blocks every younger port.
      for (int p = 0; p < NUM_SQ_DCACHE; p++) begin
         p_valid     = sq_dcache_packet[p][67];
         p_addr      = sq_dcache_packet[p][66:35];
         unused_sign = unused_sign ^ sq_dcache_packet[p][34];
         p_size      = sq_dcache_packet[p][33:32];
         p_data      = sq_dcache_packet[p][31:0];

         case (p_size)
            2'b00: begin
               lane_mask = 4'b0001 << p_addr[1:0];
               lane_data = {4{p_data[7:0]}};
            end
            2'b01: begin
               lane_mask = p_addr[1] ? 4'b1100 : 4'b0011;
               lane_data = {2{p_data[15:0]}};
            end
            default: begin
               lane_mask = 4'hF;
               lane_data = p_data;
            end
         endcase

         yi    = (n_tail == '0) ? IDX_LAST : n_tail - 1'b1;
         merge = (n_count != '0) && (n_waddr[yi] == p_addr[31:2])
                 && !((yi == head) && mem_req_valid);

         if (blocked || !p_valid) begin
            blocked = 1'b1;
         end else if (merge) begin
            for (int b = 0; b < 4; b++)
               if (lane_mask[b]) n_data[yi][8*b +: 8] = lane_data[8*b +: 8];
            n_mask[yi] = n_mask[yi] | lane_mask;
            dcache_accept[p] = 1'b1;
         end else if (n_count < LEN_C) begin
            n_valid[n_tail] = 1'b1;
            n_waddr[n_tail] = p_addr[31:2];
            n_mask[n_tail]  = lane_mask;
            for (int b = 0; b < 4; b++)
               n_data[n_tail][8*b +: 8] = lane_mask[b] ? lane_data[8*b +: 8] : 8'h00;
            n_tail  = next_idx(n_tail);
            n_count = n_count + 1'b1;
            dcache_accept[p] = 1'b1;
         end else begin
            blocked = 1'b1;
         end
      end

      // The drain uses the pre-allocation count check above, so freed space waits a cycle.
      drain = mem_req_valid && mem_req_ready;
      if (drain) begin
         n_valid[head] = 1'b0;
         n_waddr[head] = '0;
         n_data[head]  = '0;
         n_mask[head]  = '0;
         n_head        = next_idx(head);
         n_count       = n_count - 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < WB_LEN; i++) begin
            e_valid[i] <= 1'b0;
            e_waddr[i] <= '0;
            e_data[i]  <= '0;
            e_mask[i]  <= '0;
         end
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         e_valid <= n_valid;
         e_waddr <= n_waddr;
         e_data  <= n_data;
         e_mask  <= n_mask;
         head    <= n_head;
         tail    <= n_tail;
         count   <= n_count;
      end
   end

   assign mem_req_valid = e_valid[head];
   assign mem_req_addr  = mem_req_valid ? {e_waddr[head], 2'b00} : '0;
   assign mem_req_data  = mem_req_valid ? e_data[head] : '0;
   assign mem_req_mask  = mem_req_valid ? e_mask[head] : '0;
   assign wb_count      = count;
   assign wb_empty      = (count == '0);

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: a queue-based model checked every cycle,
// plus hand-computed literal checks at the interesting points.
`timescale 1ns/1ps
module tb_store_write_buffer;

   localparam int WB_LEN = 4;

   logic              clock;
   logic              reset;
   logic [1:0][67:0]  pkts;
   logic [1:0]        dcache_accept;
   logic              mem_req_valid;
   logic [31:0]       mem_req_addr;
   logic [31:0]       mem_req_data;
   logic [3:0]        mem_req_mask;
   logic              mem_req_ready;
   logic [2:0]        wb_count;
   logic              wb_empty;

   int nChecks = 0;
   int nFail   = 0;
   bit checking = 0;

   typedef struct {
      logic [29:0] waddr;
      logic [31:0] data;
      logic [3:0]  mask;
   } entry_t;

   entry_t mq[$];

   store_write_buffer #(.NUM_SQ_DCACHE(2), .WB_LEN(WB_LEN)) dut (
      .clock(clock),
      .reset(reset),
      .sq_dcache_packet(pkts),
      .dcache_accept(dcache_accept),
      .mem_req_valid(mem_req_valid),
      .mem_req_addr(mem_req_addr),
      .mem_req_data(mem_req_data),
      .mem_req_mask(mem_req_mask),
      .mem_req_ready(mem_req_ready),
      .wb_count(wb_count),
      .wb_empty(wb_empty)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   localparam logic [1:0] SB = 2'b00;
   localparam logic [1:0] SH = 2'b01;
   localparam logic [1:0] SW = 2'b10;
   localparam logic [67:0] NONE = '0;

   function automatic logic [67:0] pk(input logic [31:0] a, input logic [1:0] sz,
                                      input logic [31:0] d);
      return {1'b1, a, 1'b0, sz, d};
   endfunction

   // Model: the buffer is a FIFO of words; returns this cycle's accepts and optionally commits.
   function automatic logic [1:0] evalCycle(input bit commit);
      entry_t      tq[$];
      entry_t      ne;
      logic [1:0]  acc;
      bit          blocked, presented;
      logic [67:0] k;
      logic [31:0] a, d, nd, bm;
      logic [1:0]  sz;
      logic [3:0]  m;
      int          last;
      tq        = mq;
      acc       = '0;
      blocked   = reset;
      presented = (mq.size() > 0);
      for (int p = 0; p < 2; p++) begin
         k  = pkts[p];
         a  = k[66:35];
         sz = k[33:32];
         d  = k[31:0];
         if (blocked || !k[67]) begin
            blocked = 1;
         end else begin
            if (sz == SB) begin
               m  = 4'(1 << a[1:0]);
               nd = (d & 32'hFF) << (8 * a[1:0]);
            end else if (sz == SH) begin
               m  = 4'(3 << (2 * a[1]));
               nd = (d & 32'hFFFF) << (16 * a[1]);
            end else begin
               m  = 4'hF;
               nd = d;
            end
            bm = '0;
            for (int b = 0; b < 4; b++) if (m[b]) bm = bm | (32'hFF << (8 * b));
            last = tq.size() - 1;
            if (tq.size() > 0 && tq[last].waddr == a[31:2] && !(tq.size() == 1 && presented)) begin
               tq[last].data = (tq[last].data & ~bm) | nd;
               tq[last].mask = tq[last].mask | m;
               acc[p] = 1'b1;
            end else if (tq.size() < WB_LEN) begin
               ne.waddr = a[31:2];
               ne.data  = nd;
               ne.mask  = m;
               tq.push_back(ne);
               acc[p] = 1'b1;
            end else begin
               blocked = 1;
            end
         end
      end
      if (presented && mem_req_ready && !reset) tq.delete(0);
      if (commit) mq = tq;
      return acc;
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) mq.delete();
      else void'(evalCycle(1'b1));
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clock) begin
      if (checking) begin
         checkOutput("cmp_accept", 32'(dcache_accept), 32'(evalCycle(1'b0)));
         checkOutput("cmp_valid", 32'(mem_req_valid), 32'(mq.size() > 0));
         checkOutput("cmp_addr", mem_req_addr, mq.size() > 0 ? {mq[0].waddr, 2'b00} : 32'h0);
         checkOutput("cmp_data", mem_req_data, mq.size() > 0 ? mq[0].data : 32'h0);
         checkOutput("cmp_mask", 32'(mem_req_mask), mq.size() > 0 ? 32'(mq[0].mask) : 32'h0);
         checkOutput("cmp_count", 32'(wb_count), 32'(mq.size()));
         checkOutput("cmp_empty", 32'(wb_empty), 32'(mq.size() == 0));
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [67:0] p0, input logic [67:0] p1, input logic rdy);
      pkts[0]       = p0;
      pkts[1]       = p1;
      mem_req_ready = rdy;
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(NONE, NONE, 1'b0);
      repeat (2) tick();
      checking = 1;
      #2;
      checkOutput("rst_valid", 32'(mem_req_valid), 32'h0);
      checkOutput("rst_count", 32'(wb_count), 32'h0);
      checkOutput("rst_empty", 32'(wb_empty), 32'h1);
      checkOutput("rst_accept", 32'(dcache_accept), 32'h0);
      tick();
      reset = 1'b0;

      $display("[TB] single word store");
      tick(); applyStimulus(pk(32'h100, SW, 32'hDEADBEEF), NONE, 1'b1); #2;
      checkOutput("sw_accept", 32'(dcache_accept), 32'h1);
      tick(); applyStimulus(NONE, NONE, 1'b1); #2;
      checkOutput("sw_valid", 32'(mem_req_valid), 32'h1);
      checkOutput("sw_addr", mem_req_addr, 32'h100);
      checkOutput("sw_data", mem_req_data, 32'hDEADBEEF);
      checkOutput("sw_mask", 32'(mem_req_mask), 32'hF);
      tick(); applyStimulus(NONE, NONE, 1'b0); #2;
      checkOutput("sw_empty", 32'(wb_empty), 32'h1);

      $display("[TB] same-cycle coalesce");
      tick(); applyStimulus(pk(32'h203, SB, 32'hAA), pk(32'h200, SH, 32'h1234), 1'b0); #2;
      checkOutput("co_accept", 32'(dcache_accept), 32'h3);
      tick(); applyStimulus(NONE, NONE, 1'b1); #2;
      checkOutput("co_count", 32'(wb_count), 32'h1);
      checkOutput("co_addr", mem_req_addr, 32'h200);
      checkOutput("co_mask", 32'(mem_req_mask), 32'hB);
      checkOutput("co_data", mem_req_data, 32'hAA001234);
      tick(); applyStimulus(NONE, NONE, 1'b0); #2;
      checkOutput("co_empty", 32'(wb_empty), 32'h1);

      $display("[TB] full buffer and prefix accept");
      tick(); applyStimulus(pk(32'h0, SW, 32'hA0), pk(32'h10, SW, 32'hA1), 1'b0); #2;
      checkOutput("fill_acc0", 32'(dcache_accept), 32'h3);
      tick(); applyStimulus(pk(32'h20, SW, 32'hA2), pk(32'h30, SW, 32'hA3), 1'b0); #2;
      checkOutput("fill_acc1", 32'(dcache_accept), 32'h3);
      tick(); applyStimulus(pk(32'h40, SW, 32'hA4), pk(32'h30, SW, 32'h33), 1'b0); #2;
      checkOutput("full_acc", 32'(dcache_accept), 32'h0);
      checkOutput("full_count", 32'(wb_count), 32'h4);
      tick(); applyStimulus(pk(32'h30, SW, 32'h5555), NONE, 1'b0); #2;
      checkOutput("full_merge_acc", 32'(dcache_accept), 32'h1);
      tick(); applyStimulus(NONE, NONE, 1'b1); #2;
      checkOutput("full_merge_count", 32'(wb_count), 32'h4);
      for (int i = 0; i < 4; i++) begin
         checkOutput("full_drain_addr", mem_req_addr, 32'(i * 16));
         if (i == 3) checkOutput("full_drain_data", mem_req_data, 32'h5555);
         tick(); #1;
      end
      checkOutput("full_drained", 32'(wb_empty), 32'h1);

      $display("[TB] no merge into presented head");
      tick(); applyStimulus(pk(32'h80, SW, 32'h11223344), NONE, 1'b0); #2;
      checkOutput("head_acc0", 32'(dcache_accept), 32'h1);
      tick(); applyStimulus(pk(32'h81, SB, 32'h77), NONE, 1'b0); #2;
      checkOutput("head_acc1", 32'(dcache_accept), 32'h1);
      tick(); applyStimulus(NONE, NONE, 1'b1); #2;
      checkOutput("head_count", 32'(wb_count), 32'h2);
      checkOutput("head_mask0", 32'(mem_req_mask), 32'hF);
      tick(); #2;
      checkOutput("head_addr1", mem_req_addr, 32'h80);
      checkOutput("head_mask1", 32'(mem_req_mask), 32'h2);
      checkOutput("head_data1", mem_req_data, 32'h00007700);
      tick(); applyStimulus(NONE, NONE, 1'b0); #2;
      checkOutput("head_empty", 32'(wb_empty), 32'h1);

      $display("[TB] full with drain, no same-cycle reuse, tail wrap");
      tick(); applyStimulus(pk(32'h400, SW, 32'h1), pk(32'h404, SW, 32'h2), 1'b0); #2;
      tick(); applyStimulus(pk(32'h408, SW, 32'h3), pk(32'h40C, SW, 32'h4), 1'b0); #2;
      tick(); applyStimulus(pk(32'h500, SW, 32'h5), pk(32'h504, SW, 32'h6), 1'b1); #2;
      checkOutput("reuse_acc0", 32'(dcache_accept), 32'h0);
      checkOutput("reuse_count0", 32'(wb_count), 32'h4);
      tick(); #2;
      checkOutput("reuse_acc1", 32'(dcache_accept), 32'h1);
      checkOutput("reuse_count1", 32'(wb_count), 32'h3);
      tick(); applyStimulus(NONE, NONE, 1'b1); #2;
      checkOutput("wrap_addr0", mem_req_addr, 32'h408);
      tick(); #2;
      checkOutput("wrap_addr1", mem_req_addr, 32'h40C);
      tick(); #2;
      checkOutput("wrap_addr2", mem_req_addr, 32'h500);
      checkOutput("wrap_data2", mem_req_data, 32'h5);
      tick(); applyStimulus(NONE, NONE, 1'b0); #2;
      checkOutput("wrap_empty", 32'(wb_empty), 32'h1);

      $display("[TB] asynchronous reset mid-handshake");
      tick(); applyStimulus(pk(32'h600, SW, 32'h66), NONE, 1'b0); #2;
      tick(); applyStimulus(NONE, NONE, 1'b0); #1;
      checkOutput("ar_valid_before", 32'(mem_req_valid), 32'h1);
      #1 reset = 1'b1;
      #1;
      checkOutput("ar_valid", 32'(mem_req_valid), 32'h0);
      checkOutput("ar_count", 32'(wb_count), 32'h0);
      checkOutput("ar_addr", mem_req_addr, 32'h0);
      applyStimulus(pk(32'h700, SW, 32'h77), NONE, 1'b0); #1;
      checkOutput("ar_accept", 32'(dcache_accept), 32'h0);
      tick(); tick();
      reset = 1'b0;
      #2;
      checkOutput("ar_post_acc", 32'(dcache_accept), 32'h1);
      tick(); applyStimulus(NONE, NONE, 1'b0); #2;
      checkOutput("ar_post_addr", mem_req_addr, 32'h700);
      checkOutput("ar_post_count", 32'(wb_count), 32'h1);
      tick(); applyStimulus(NONE, NONE, 1'b1);
      repeat (3) tick();
      checking = 0;

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
